// File: rtl/lfsr_ram_pkg.sv
// Shared constants for the lfsr/ram random-pattern buffer.
// State encoding and default geometry live here.
package lfsr_ram_pkg;

   localparam int DW_DEF    = 6;
   localparam int DEPTH_DEF = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_FILL  = 3'd2;
   localparam logic [2:0] ST_PREF  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/lfsr_rnd_buf_if.sv
// Valid/ready stream carrying buffered LFSR words.
// master drives data/valid, slave drives ready.
interface lfsr_rnd_buf_if #(
   parameter int DW = 6
) ();

   logic [DW-1:0] data;
   logic          valid;
   logic          ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );

endinterface

// File: rtl/rbuf_mem.sv
// Register array: one synchronous write port, one async read port.
// Contents are not reset; every run overwrites all words before reading.
module rbuf_mem #(
   parameter int DW    = 6,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // capture one word per enabled edge
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lfsr_rnd_buf.sv
// Seeds the LFSR, captures DEPTH consecutive states, then streams them out.
// FSM and pointers live here; storage is the rbuf_mem array.
module lfsr_rnd_buf
   import lfsr_ram_pkg::*;
#(
   parameter int DW_RBUF    = DW_DEF,
   parameter int DEPTH_RBUF = DEPTH_DEF
) (
   input  logic               i_clk_rbuf,
   input  logic               i_rst_rbuf,
   input  logic               i_start_rbuf,
   input  logic [DW_RBUF-1:0] i_seed_rbuf,
   input  logic [DW_RBUF-1:0] i_rnd_rbuf,
   output logic               o_lfsr_en_rbuf,
   output logic               o_lfsr_ld_rbuf,
   output logic [DW_RBUF-1:0] o_lfsr_seed_rbuf,
   output logic               o_busy_rbuf,
   output logic               o_done_rbuf,
   lfsr_rnd_buf_if.master     strm
);

   localparam int AW_RBUF = $clog2(DEPTH_RBUF);
   localparam logic [AW_RBUF-1:0] LAST = AW_RBUF'(DEPTH_RBUF - 1);
   localparam logic [AW_RBUF-1:0] ONE  = AW_RBUF'(1);

   logic [2:0]         state;
   logic [AW_RBUF-1:0] wr_ptr;
   logic [AW_RBUF-1:0] rd_ptr;
   logic [AW_RBUF-1:0] rd_addr;
   logic [DW_RBUF-1:0] seed_q;
   logic [DW_RBUF-1:0] data_q;
   logic [DW_RBUF-1:0] rd_data;
   logic               valid_q;
   logic               done_q;
   logic               wr_en;
   logic               xfer;

   assign wr_en = (state == ST_FILL);
   assign xfer  = valid_q & strm.ready;

   // PREF fetches word 0; DRAIN looks one word ahead so a
   // handshake can reload o_data without a bubble
   always_comb begin
      rd_addr = '0;
      if (state == ST_DRAIN) begin
         rd_addr = rd_ptr + ONE;
      end
   end

   rbuf_mem #(
      .DW    (DW_RBUF),
      .DEPTH (DEPTH_RBUF),
      .AW    (AW_RBUF)
   ) u_mem (
      .clk   (i_clk_rbuf),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (i_rnd_rbuf),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // sequencer: seed, fill, prefetch, drain, done
   always_ff @(posedge i_clk_rbuf) begin
      if (i_rst_rbuf) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start_rbuf) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= ST_FILL;
            end
            ST_FILL: begin
               if (wr_ptr == LAST) begin
                  state <= ST_PREF;
               end
            end
            ST_PREF: begin
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (xfer && rd_ptr == LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // seed is latched only when a start is accepted
   always_ff @(posedge i_clk_rbuf) begin
      if (i_rst_rbuf) begin
         seed_q <= '0;
      end else if (state == ST_IDLE && i_start_rbuf) begin
         seed_q <= i_seed_rbuf;
      end
   end

   // write pointer walks 0..DEPTH-1 during FILL and wraps to 0
   always_ff @(posedge i_clk_rbuf) begin
      if (i_rst_rbuf) begin
         wr_ptr <= '0;
      end else if (state == ST_LOAD) begin
         wr_ptr <= '0;
      end else if (state == ST_FILL) begin
         wr_ptr <= wr_ptr + ONE;
      end
   end

   // read pointer restarts at fill end, advances per handshake
   always_ff @(posedge i_clk_rbuf) begin
      if (i_rst_rbuf) begin
         rd_ptr <= '0;
      end else if (state == ST_FILL && wr_ptr == LAST) begin
         rd_ptr <= '0;
      end else if (state == ST_DRAIN && xfer && rd_ptr != LAST) begin
         rd_ptr <= rd_ptr + ONE;
      end
   end

   // output register: held while stalled, reloaded on handshake
   always_ff @(posedge i_clk_rbuf) begin
      if (i_rst_rbuf) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (state == ST_PREF) begin
         data_q  <= rd_data;
         valid_q <= 1'b1;
      end else if (state == ST_DRAIN && xfer) begin
         if (rd_ptr == LAST) begin
            valid_q <= 1'b0;
         end else begin
            data_q <= rd_data;
         end
      end
   end

   // done pulse coincides with the single DONE cycle
   always_ff @(posedge i_clk_rbuf) begin
      if (i_rst_rbuf) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state == ST_DRAIN) && xfer && (rd_ptr == LAST);
      end
   end

   assign o_lfsr_en_rbuf   = (state == ST_LOAD) || (state == ST_FILL);
   assign o_lfsr_ld_rbuf   = (state == ST_LOAD);
   assign o_lfsr_seed_rbuf = seed_q;
   assign o_busy_rbuf      = (state != ST_IDLE);
   assign o_done_rbuf      = done_q;
   assign strm.data        = data_q;
   assign strm.valid       = valid_q;

endmodule

// File: tb/tb_lfsr_rnd_buf.sv
// Bench for lfsr_rnd_buf with a behavioural 6-bit LFSR attached.
// Expected words come from literal tables or a step-by-step LFSR model.
module tb_lfsr_rnd_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       ready;
   logic [5:0] seed_i;
   logic [5:0] rnd = 6'h00;
   logic       en;
   logic       ld;
   logic [5:0] lseed;
   logic       busy;
   logic       done;
   logic [5:0] data;
   logic       valid;

   int tests = 0;
   int fails = 0;

   lfsr_rnd_buf_if #(.DW(6)) strm ();

   assign strm.ready = ready;
   assign data       = strm.data;
   assign valid      = strm.valid;

   lfsr_rnd_buf #(
      .DW_RBUF    (6),
      .DEPTH_RBUF (8)
   ) dut (
      .i_clk_rbuf       (clk),
      .i_rst_rbuf       (rst),
      .i_start_rbuf     (start),
      .i_seed_rbuf      (seed_i),
      .i_rnd_rbuf       (rnd),
      .o_lfsr_en_rbuf   (en),
      .o_lfsr_ld_rbuf   (ld),
      .o_lfsr_seed_rbuf (lseed),
      .o_busy_rbuf      (busy),
      .o_done_rbuf      (done),
      .strm             (strm)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] nxt(input logic [5:0] s);
      return {s[4:0], s[4] ^ s[1]};
   endfunction

   // the upstream LFSR: load on en&ld, step on en
   always_ff @(posedge clk) begin
      if (en) begin
         rnd <= ld ? lseed : nxt(rnd);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model(input logic [5:0] s, output logic [5:0] ew [8]);
      ew[0] = s;
      for (int k = 1; k < 8; k++) begin
         ew[k] = nxt(ew[k-1]);
      end
   endtask

   // rmode: 0 ready high, 1 pattern 1,0,0 repeating, 2 random
   task automatic run(input logic [5:0] seed, input int rmode,
                      input int poke_a, input int poke_b,
                      input logic [5:0] ew [8], input bit lat);
      int         cyc;
      int         idx;
      int         first_v;
      int         done_cyc;
      int         done_cnt;
      logic       stall;
      logic [5:0] held;
      idx      = 0;
      first_v  = -1;
      done_cyc = -1;
      done_cnt = 0;
      stall    = 1'b0;
      held     = '0;
      start    = 1'b1;
      seed_i   = seed;
      step();
      start = 1'b0;
      cyc   = 1;
      while (done_cnt == 0 && cyc < 200) begin
         start = (cyc == poke_a) || (cyc == poke_b);
         seed_i = 6'($urandom);
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = ((cyc % 3) == 2);
            default: ready = 1'($urandom);
         endcase
         if (lat && cyc == 1) begin
            chk("load_ld", ld, 1);
            chk("load_en", en, 1);
            chk("load_seed", lseed, seed);
         end
         if (lat && cyc == 2) begin
            chk("fill_ld", ld, 0);
            chk("fill_en", en, 1);
         end
         if (lat && cyc == 10) begin
            chk("pref_en", en, 0);
            chk("pref_valid", valid, 0);
         end
         chk("busy_run", busy, 1);
         if (stall) begin
            chk("hold_valid", valid, 1);
            chk("hold_data", data, held);
         end
         if (valid && first_v < 0) first_v = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (valid && ready) begin
            if (idx < 8) chk($sformatf("word%0d", idx), data, ew[idx]);
            else chk("extra_word", idx, 7);
            idx++;
         end
         stall = valid && !ready;
         held  = data;
         step();
         cyc++;
      end
      start = 1'b0;
      chk("nwords", idx, 8);
      chk("ndone", done_cnt, 1);
      if (lat) begin
         chk("first_valid_cyc", first_v, 11);
         chk("done_cyc", done_cyc, 19);
      end
      for (int k = 0; k < 3; k++) begin
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_valid", valid, 0);
         step();
      end
   endtask

   initial begin
      logic [5:0] lit [8];
      logic [5:0] ew [8];
      logic [5:0] words [$];
      int         cyc;
      int         ldc;
      int         blow;
      int         dcnt;
      lit = '{6'h01, 6'h02, 6'h05, 6'h0A, 6'h15, 6'h2B, 6'h17, 6'h2E};

      rst    = 1'b1;
      start  = 1'b0;
      ready  = 1'b0;
      seed_i = 6'h00;
      step();
      step();
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_en", en, 0);
      chk("rst_ld", ld, 0);
      chk("rst_seed", lseed, 0);
      rst = 1'b0;
      step();

      run(6'h01, 0, 0, 0, lit, 1'b1);
      run(6'h01, 1, 0, 0, lit, 1'b0);
      run(6'h01, 2, 4, 14, lit, 1'b0);

      start  = 1'b1;
      seed_i = 6'h2A;
      step();
      start = 1'b0;
      step();
      step();
      step();
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("post_rst_valid", valid, 0);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_en", en, 0);
         chk("post_rst_ld", ld, 0);
         step();
      end
      model(6'h05, ew);
      run(6'h05, 0, 0, 0, ew, 1'b1);

      model(6'h00, ew);
      run(6'h00, 2, 0, 0, ew, 1'b0);

      for (int r = 0; r < 3; r++) begin
         logic [5:0] s;
         s = 6'($urandom);
         model(s, ew);
         run(s, 2, 0, 0, ew, 1'b0);
      end

      start  = 1'b1;
      seed_i = 6'h01;
      ready  = 1'b1;
      step();
      cyc  = 1;
      ldc  = 0;
      blow = 0;
      dcnt = 0;
      while (dcnt < 2 && cyc < 200) begin
         if (ld) ldc++;
         if (!busy) blow++;
         if (done) dcnt++;
         if (valid && ready) words.push_back(data);
         if (ldc >= 2) start = 1'b0;
         step();
         cyc++;
      end
      start = 1'b0;
      chk("b2b_done", dcnt, 2);
      chk("b2b_ld", ldc, 2);
      chk("b2b_idle", blow, 1);
      chk("b2b_words", words.size(), 16);
      for (int i = 0; i < words.size() && i < 16; i++) begin
         chk($sformatf("b2b_word%0d", i), words[i], lit[i % 8]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
